// File: rtl/kingproc_pkg.sv
// Shared definitions for the fetch unit: widths, instruction field positions, FSM states.
package kingproc_pkg;

  localparam int LARGURA_PC     = 10;
  localparam int LARGURA_INSTR  = 32;
  localparam int LARGURA_OPCODE = 6;
  localparam int OPCODE_MSB     = 31;
  localparam int OPCODE_LSB     = 26;
  localparam int ALVO_MSB       = 9;
  localparam int ALVO_LSB       = 0;

  typedef enum logic [2:0] {
    BUSCA,
    CARREGA,
    EXECUTA,
    ESPERA,
    PARADO
  } estado_t;

  // Sequential PC step; the 10-bit width gives the 1023 -> 0 wrap for free.
  function automatic logic [LARGURA_PC-1:0] incrementa_pc(input logic [LARGURA_PC-1:0] pc);
    return pc + LARGURA_PC'(1);
  endfunction

endpackage

// File: rtl/detector_borda.sv
// Two-flop synchroniser for an asynchronous button level, followed by a rising-edge detector.
// pulso_o is high for exactly one core cycle per clean 0->1 transition of the synchronised level.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic assinc_i,
  output logic pulso_o
);

  logic sinc1_q;
  logic sinc2_q;
  logic anterior_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sinc1_q    <= 1'b0;
      sinc2_q    <= 1'b0;
      anterior_q <= 1'b0;
    end else begin
      sinc1_q    <= assinc_i;
      sinc2_q    <= sinc1_q;
      anterior_q <= sinc2_q;
    end
  end

  assign pulso_o = sinc2_q & ~anterior_q;

endmodule

// File: rtl/unidade_de_busca.sv
// Fetch/sequencing unit: BUSCA -> CARREGA -> EXECUTA, with ESPERA for user input and PARADO on halt.
// Optional BUSCA_PASSO_A_PASSO_EN adds a 'passo' button that gates each fetch (single-step mode).
module unidade_de_busca
  import kingproc_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LARGURA_INSTR-1:0]  instrucao_mem,
  input  logic                      Desvio,
  input  logic                      trava,
  input  logic                      espera_entrada,
  input  logic                      cond_desvio,
  input  logic                      entrada_pronta,
`ifdef BUSCA_PASSO_A_PASSO_EN
  input  logic                      passo,
`endif
  output logic [LARGURA_PC-1:0]     endereco_mem,
  output logic [LARGURA_INSTR-1:0]  instrucao,
  output logic [LARGURA_OPCODE-1:0] opcode,
  output logic                      habilita_escrita,
  output logic                      parado
);

  estado_t                  estado_q, estado_d;
  logic [LARGURA_PC-1:0]    pc_q, pc_d;
  logic [LARGURA_INSTR-1:0] ir_q, ir_d;
  logic                     commit;
  logic                     pulso_entrada;
  logic                     avanca_busca;

  detector_borda u_borda_entrada (
    .clk      (clk),
    .rst      (rst),
    .assinc_i (entrada_pronta),
    .pulso_o  (pulso_entrada)
  );

`ifdef BUSCA_PASSO_A_PASSO_EN
  detector_borda u_borda_passo (
    .clk      (clk),
    .rst      (rst),
    .assinc_i (passo),
    .pulso_o  (avanca_busca)
  );
`else
  assign avanca_busca = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= BUSCA;
      pc_q     <= '0;
      ir_q     <= '0;
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    commit   = 1'b0;
    case (estado_q)
      BUSCA: begin
        if (avanca_busca) estado_d = CARREGA;
      end
      CARREGA: begin
        ir_d     = instrucao_mem;
        estado_d = EXECUTA;
      end
      EXECUTA: begin
        // Halt outranks input-wait, which outranks any branch decision.
        if (trava) begin
          estado_d = PARADO;
        end else if (espera_entrada) begin
          estado_d = ESPERA;
        end else begin
          commit   = 1'b1;
          pc_d     = (Desvio && cond_desvio) ? ir_q[ALVO_MSB:ALVO_LSB] : incrementa_pc(pc_q);
          estado_d = BUSCA;
        end
      end
      ESPERA: begin
        if (pulso_entrada) begin
          commit   = 1'b1;
          pc_d     = incrementa_pc(pc_q);
          estado_d = BUSCA;
        end
      end
      PARADO: begin
        estado_d = PARADO;
      end
      default: begin
        estado_d = BUSCA;
      end
    endcase
  end

  // A commit in the reset cycle would act on a machine that is about to be cleared.
  assign habilita_escrita = commit & ~rst;
  assign endereco_mem     = pc_q;
  assign instrucao        = ir_q;
  assign opcode           = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign parado           = (estado_q == PARADO);

endmodule

// File: tb/tb_unidade_de_busca.sv
// Directed bench: ROM model + control-unit decode; expectations queued by stimulus, checked by a negedge monitor.
module tb_unidade_de_busca;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instrucao_mem = '0;
  logic        Desvio, trava, espera_entrada, cond_desvio;
  logic        entrada_pronta = 1'b0;
  logic [9:0]  endereco_mem;
  logic [31:0] instrucao;
  logic [5:0]  opcode;
  logic        habilita_escrita, parado;

  unidade_de_busca dut (
    .clk              (clk),
    .rst              (rst),
    .instrucao_mem    (instrucao_mem),
    .Desvio           (Desvio),
    .trava            (trava),
    .espera_entrada   (espera_entrada),
    .cond_desvio      (cond_desvio),
    .entrada_pronta   (entrada_pronta),
    .endereco_mem     (endereco_mem),
    .instrucao        (instrucao),
    .opcode           (opcode),
    .habilita_escrita (habilita_escrita),
    .parado           (parado)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle after it is presented.
  logic [31:0] rom [0:1023];
  always @(posedge clk) instrucao_mem <= rom[endereco_mem];

  // Control-unit model: opcode bit5=halt, bit4=input, bit3=branch; IR[25] stands in for the ALU flag.
  assign trava          = instrucao[31];
  assign espera_entrada = instrucao[30];
  assign Desvio         = instrucao[29];
  assign cond_desvio    = instrucao[25];

  localparam int C_END = 0, C_PAR = 1, C_INS = 2, C_OPC = 3;

  typedef struct { int ciclo; logic [9:0] pc; } commit_t;
  typedef struct { int ciclo; int campo; logic [31:0] valor; } amostra_t;

  commit_t  fila_commit[$];
  amostra_t fila_amostra[$];

  int cyc = 0;
  int rst_rel = 0;
  int tests = 0;
  int fails = 0;
  bit done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] le_campo(input int campo);
    case (campo)
      C_END:   return {22'b0, endereco_mem};
      C_PAR:   return {31'b0, parado};
      C_INS:   return instrucao;
      C_OPC:   return {26'b0, opcode};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string nome_campo(input int campo);
    case (campo)
      C_END:   return "endereco_mem";
      C_PAR:   return "parado";
      C_INS:   return "instrucao";
      C_OPC:   return "opcode";
      default: return "desconhecido";
    endcase
  endfunction

  always @(negedge clk) begin
    int      agora;
    commit_t c;
    amostra_t a;
    agora = cyc - rst_rel + 1;

    while (fila_commit.size() > 0 && fila_commit[0].ciclo < agora && !habilita_escrita) begin
      c = fila_commit.pop_front();
      tests++;
      fails++;
      $display("FAIL commit_ausente: got no strobe by ciclo %0d, expected pc=%0h at ciclo %0d", agora, c.pc, c.ciclo);
    end

    if (habilita_escrita) begin
      tests++;
      if (fila_commit.size() == 0) begin
        fails++;
        $display("FAIL commit_inesperado: got strobe at ciclo %0d pc=%0h, expected none", agora, endereco_mem);
      end else begin
        c = fila_commit.pop_front();
        if (c.pc !== endereco_mem || c.ciclo != agora) begin
          fails++;
          $display("FAIL commit: got pc=%0h ciclo %0d, expected pc=%0h ciclo %0d", endereco_mem, agora, c.pc, c.ciclo);
        end
      end
    end

    while (fila_amostra.size() > 0 && fila_amostra[0].ciclo <= agora) begin
      a = fila_amostra.pop_front();
      tests++;
      if (a.ciclo < agora) begin
        fails++;
        $display("FAIL amostra_perdida %s: expected %0h at ciclo %0d, reached ciclo %0d", nome_campo(a.campo), a.valor, a.ciclo, agora);
      end else if (le_campo(a.campo) !== a.valor) begin
        fails++;
        $display("FAIL %s ciclo %0d: got %0h, expected %0h", nome_campo(a.campo), agora, le_campo(a.campo), a.valor);
      end
    end

    if (done || cyc > 5000) begin
      if (!done) begin
        tests++;
        fails++;
        $display("FAIL timeout: got cyc=%0d without completion, expected done", cyc);
      end
      tests++;
      if (fila_commit.size() != 0 || fila_amostra.size() != 0) begin
        fails++;
        $display("FAIL filas_pendentes: got %0d commits / %0d amostras left, expected 0 / 0", fila_commit.size(), fila_amostra.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic esp(input int ciclo, input int campo, input logic [31:0] valor);
    amostra_t a;
    a.ciclo = ciclo; a.campo = campo; a.valor = valor;
    fila_amostra.push_back(a);
  endtask

  task automatic esp_commit(input int ciclo, input logic [9:0] pc);
    commit_t c;
    c.ciclo = ciclo; c.pc = pc;
    fila_commit.push_back(c);
  endtask

  // After return, cycle 1 (state BUSCA, first after reset) is in progress.
  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_rel = cyc;
  endtask

  task automatic wait_cycle(input int k);
    while (cyc - rst_rel + 1 < k) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'h0;

    // Straight-line ALU ops, taken branch to 0x3F0, untaken branch, taken branch to 0x3FF, wrap to 0.
    rom[0]      = 32'h0000_0011;
    rom[1]      = 32'h0000_0012;
    rom[2]      = 32'h0000_0013;
    rom[3]      = 32'h2200_03F0;
    rom[10'h3F0] = 32'h2000_0005;
    rom[10'h3F1] = 32'h2200_03FF;
    rom[10'h3FF] = 32'h0000_0022;
    reset_dut();
    esp(1, C_END, 32'h0);   esp(1, C_PAR, 32'h0);
    esp(1, C_INS, 32'h0);   esp(1, C_OPC, 32'h0);
    esp(2, C_END, 32'h0);   esp(4, C_END, 32'h1);
    esp(7, C_END, 32'h2);   esp(10, C_END, 32'h3);
    esp(13, C_END, 32'h3F0); esp(13, C_INS, 32'h2200_03F0); esp(13, C_OPC, 32'h08);
    esp(16, C_END, 32'h3F1); esp(19, C_END, 32'h3FF); esp(22, C_END, 32'h0);
    esp_commit(3, 10'h0);    esp_commit(6, 10'h1);    esp_commit(9, 10'h2);
    esp_commit(12, 10'h3);   esp_commit(15, 10'h3F0); esp_commit(18, 10'h3F1);
    esp_commit(21, 10'h3FF);
    wait_cycle(22);

    // Input-wait: level already high must not release; only the later fresh edge does.
    rom[0] = 32'h4000_0000;
    rom[1] = 32'h8000_0000;
    entrada_pronta = 1'b1;
    reset_dut();
    esp(20, C_END, 32'h0);  esp(20, C_PAR, 32'h0);
    esp(29, C_END, 32'h1);  esp(31, C_PAR, 32'h0);
    esp(32, C_PAR, 32'h1);  esp(32, C_END, 32'h1);
    esp_commit(28, 10'h0);
    wait_cycle(23);
    entrada_pronta = 1'b0;
    wait_cycle(26);
    entrada_pronta = 1'b1;
    wait_cycle(33);

    // Halt together with a taken branch: PC frozen at the halt address.
    rom[0] = 32'h0000_0011;
    rom[1] = 32'hA200_03F0;
    entrada_pronta = 1'b0;
    reset_dut();
    esp_commit(3, 10'h0);
    esp(6, C_PAR, 32'h0);   esp(6, C_END, 32'h1);
    for (int c = 7; c <= 56; c++) begin
      esp(c, C_END, 32'h1);
      esp(c, C_PAR, 32'h1);
    end
    wait_cycle(57);

    // Input-wait with a taken branch pending, then reset while waiting.
    rom[0] = 32'h6200_03F0;
    reset_dut();
    esp(1, C_END, 32'h0);   esp(1, C_PAR, 32'h0);
    esp(5, C_END, 32'h0);   esp(5, C_PAR, 32'h0);
    wait_cycle(5);
    entrada_pronta = 1'b1;
    wait_cycle(6);
    rst = 1'b1;
    rom[0] = 32'h0000_0011;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_rel = cyc;
    esp(1, C_END, 32'h0);   esp(1, C_PAR, 32'h0);   esp(1, C_INS, 32'h0);
    esp(2, C_END, 32'h0);
    esp_commit(3, 10'h0);
    esp(4, C_END, 32'h1);
    wait_cycle(4);
    done = 1'b1;
  end

endmodule

// File: doc/unidade_de_busca.md
UNIDADE_DE_BUSCA -- requirements
Module: unidade_de_busca

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-003 SHALL have port instrucao_mem, input, 32, instruction ROM read data, valid one cycle after endereco_mem is presented.
REQ-004 SHALL have port Desvio, input, 1, branch-instruction flag from the control unit.
REQ-005 SHALL have port trava, input, 1, halt-instruction flag from the control unit.
REQ-006 SHALL have port espera_entrada, input, 1, current instruction needs user input.
REQ-007 SHALL have port cond_desvio, input, 1, ALU branch-taken flag.
REQ-008 SHALL have port entrada_pronta, input, 1, asynchronous user-confirm level (button).
REQ-009 SHALL have port endereco_mem, output, 10, instruction ROM address (= PC).
REQ-010 SHALL have port instrucao, output, 32, registered instruction (IR).
REQ-011 SHALL have port opcode, output, 6, IR[31:26], feeds the control unit.
REQ-012 SHALL have port habilita_escrita, output, 1, one-cycle commit strobe gating RegWrite/MemWrite.
REQ-013 SHALL have port parado, output, 1, high while halted.

Function
REQ-014 SHALL implement FSM states BUSCA, CARREGA, EXECUTA, ESPERA, PARADO.
REQ-015 BUSCA SHALL drive endereco_mem=PC and go to CARREGA next cycle.
REQ-016 CARREGA SHALL load IR<=instrucao_mem at cycle end and go to EXECUTA; fetch-to-execute latency is 2 cycles.
REQ-017 EXECUTA with trava=1 SHALL go to PARADO, PC unchanged, habilita_escrita=0.
REQ-018 EXECUTA with espera_entrada=1 SHALL go to ESPERA, habilita_escrita=0, PC unchanged.
REQ-019 EXECUTA otherwise SHALL assert habilita_escrita for exactly that cycle, update PC, and go to BUSCA.
REQ-020 PC update SHALL be PC<=IR[9:0] when Desvio&&cond_desvio, else PC<=PC+1 modulo 1024 (1023 wraps to 0).
REQ-021 ESPERA SHALL remain until a synchronised rising edge of entrada_pronta, then assert habilita_escrita one cycle, PC<=PC+1, and go to BUSCA.
REQ-022 A level held high on entrada_pronta SHALL NOT release a second ESPERA; only a new edge does.
REQ-023 entrada_pronta SHALL pass through a 2-flop synchroniser before edge detection.
REQ-024 PARADO SHALL be left only by rst; parado=1 in PARADO, else 0.
REQ-025 trava SHALL take priority over espera_entrada and Desvio when several are high.
REQ-026 endereco_mem SHALL equal PC in every state.

Reset
REQ-027 rst SHALL force state BUSCA, PC=0, IR=0, habilita_escrita=0, parado=0, synchroniser/edge flops=0, from any state including mid-ESPERA.
REQ-028 First fetch after reset release SHALL address 0.

Configuration
REQ-029 Macro BUSCA_PASSO_A_PASSO_EN SHALL add input passo (1 bit); when defined, BUSCA SHALL advance only on a synchronised rising edge of passo (same synchroniser/edge logic as entrada_pronta). When undefined, no passo port exists and BUSCA always advances next cycle.

Structure
REQ-030 Shared package kingproc_pkg SHALL hold the FSM state typedef, LARGURA_PC=10, LARGURA_INSTR=32, opcode field position constants.
REQ-031 Sub-module detector_borda (2-flop sync + rising-edge pulse) SHALL be instantiated per asynchronous button input.

Verification
REQ-032 Reset, ROM[0..2] non-branch ALU ops -> endereco_mem 0,1,2; habilita_escrita pulses in cycles 3, 6, 9 after reset release.
REQ-033 IR[9:0]=0x3F0, Desvio=1, cond_desvio=1 -> next endereco_mem=0x3F0; cond_desvio=0 -> PC+1.
REQ-034 PC=1023, non-branch -> next PC=0.
REQ-035 espera_entrada=1, entrada_pronta held high 20 cycles then low then high -> exactly one habilita_escrita, after the second edge plus synchroniser delay.
REQ-036 trava=1 with Desvio=1 -> PARADO, parado=1, PC frozen for 50 cycles; rst pulse -> PC=0, parado=0.
REQ-037 rst asserted while in ESPERA -> BUSCA, PC=0, no habilita_escrita pulse.
